// File: rtl/pedal_pkg.sv
// pedal_pkg: shared sample type, scheduler state type and rate constant
// for the pedal audio path.
package pedal_pkg;

   typedef logic [15:0] sample_t;

   typedef enum {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} sched_state_t;

   localparam int SAMPLE_DIV_48K = 521;

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: small synchronous audio FIFO with first-word fall-through
// read data. Push while full is dropped unless a pop happens that cycle.
module sample_fifo
   import pedal_pkg::*;
#(
   parameter  int FIFO_DEPTH = 4,
   localparam int AW         = $clog2(FIFO_DEPTH),
   localparam int LW         = AW + 1
) (
   input  logic          clk_25mhz,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  sample_t       din,
   output sample_t       dout,
   output logic [LW-1:0] level,
   output logic          full,
   output logic          empty
);

   sample_t       mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (level == LW'(FIFO_DEPTH));
   assign empty   = (level == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk_25mhz or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push & ~do_pop)
            level <= level + LW'(1);
         else if (do_pop & ~do_push)
            level <= level - LW'(1);
      end
   end

   always_ff @(posedge clk_25mhz) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/dac_scheduler.sv
// dac_scheduler: paces buffered audio onto dac_driver, filling idle slots
// with config words. DAC_SCHED_UNDERRUN_HOLD_EN: underrun resends last sample.
module dac_scheduler
   import pedal_pkg::*;
#(
   parameter  int      SAMPLE_DIV = SAMPLE_DIV_48K,
   parameter  int      FIFO_DEPTH = 4,
   parameter  sample_t MUTE_WORD  = 16'h0000,
   localparam int      LW         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic          clk_25mhz,
   input  logic          reset,
   input  sample_t       audio_in,
   input  logic          audio_valid,
   input  sample_t       cfg_word,
   input  logic          cfg_req,
   output logic          cfg_ack,
   output sample_t       dac_data,
   output logic          dac_start,
   input  logic          dac_busy,
   output logic [LW-1:0] fifo_level,
   output logic          underrun,
   output logic          overflow,
   output logic          late
);

   localparam int            CW   = $clog2(SAMPLE_DIV);
   localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

   sched_state_t  state;
   sched_state_t  state_nx;
   logic [CW-1:0] slot_cnt;
   logic          tick;
   logic          slot_pending;
   logic          wait_cnt;
   logic          pop;
   sample_t       sub_word;
   sample_t       fifo_dout;
   logic          fifo_full;
   logic          fifo_empty;

   sample_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_25mhz (clk_25mhz),
      .reset     (reset),
      .push      (audio_valid),
      .pop       (pop),
      .din       (audio_in),
      .dout      (fifo_dout),
      .level     (fifo_level),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

`ifdef DAC_SCHED_UNDERRUN_HOLD_EN
   sample_t last_sample;

   always_ff @(posedge clk_25mhz or negedge reset) begin
      if (!reset)
         last_sample <= MUTE_WORD;
      else if (pop)
         last_sample <= fifo_empty ? last_sample : fifo_dout;
   end

   assign sub_word = last_sample;
`else
   assign sub_word = MUTE_WORD;
`endif

   assign tick     = (slot_cnt == LAST);
   assign underrun = pop & fifo_empty;
   assign overflow = audio_valid & fifo_full & ~pop;
   assign late     = tick & slot_pending & ~pop;

   always_ff @(posedge clk_25mhz or negedge reset) begin
      if (!reset) begin
         slot_cnt     <= '0;
         slot_pending <= 1'b0;
      end else begin
         slot_cnt     <= tick ? '0 : slot_cnt + CW'(1);
         slot_pending <= tick | (slot_pending & ~pop);
      end
   end

   always_ff @(posedge clk_25mhz or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         wait_cnt <= 1'b0;
         dac_data <= '0;
      end else begin
         state    <= state_nx;
         wait_cnt <= (state == WAIT_BUSY);
         if (pop)
            dac_data <= fifo_empty ? sub_word : fifo_dout;
         else if (cfg_ack)
            dac_data <= cfg_word;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:      if (pop | cfg_ack) state_nx = LAUNCH;
         LAUNCH:    state_nx = WAIT_BUSY;
         WAIT_BUSY: begin
            if (dac_busy)      state_nx = WAIT_DONE;
            else if (wait_cnt) state_nx = IDLE;
         end
         WAIT_DONE: if (!dac_busy) state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   // A tick blocks config this cycle so the slot it raises is served first.
   always_comb begin
      pop       = 1'b0;
      cfg_ack   = 1'b0;
      dac_start = 1'b0;
      unique case (state)
         IDLE: begin
            pop     = slot_pending;
            cfg_ack = ~slot_pending & ~tick & cfg_req & reset;
         end
         LAUNCH:  dac_start = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dac_scheduler.sv
// tb_dac_scheduler: cycle-by-cycle comparison of dac_scheduler against a
// slot/queue reference model, with directed scenarios and random traffic.
module tb_dac_scheduler;
   import pedal_pkg::*;

   localparam int          SD    = 64;
   localparam int          DEPTH = 4;
   localparam int          LW    = $clog2(DEPTH) + 1;
   localparam logic [15:0] MUTE  = 16'h0000;
   localparam bit HOLD =
`ifdef DAC_SCHED_UNDERRUN_HOLD_EN
      1'b1;
`else
      1'b0;
`endif

   logic          tb_clk_25mhz = 1'b0;
   logic          reset        = 1'b0;
   sample_t       audio_in     = '0;
   logic          audio_valid  = 1'b0;
   sample_t       cfg_word     = '0;
   logic          cfg_req      = 1'b0;
   logic          cfg_ack;
   sample_t       dac_data;
   logic          dac_start;
   logic          dac_busy     = 1'b0;
   logic [LW-1:0] fifo_level;
   logic          underrun;
   logic          overflow;
   logic          late;

   always #20 tb_clk_25mhz = ~tb_clk_25mhz;

   dac_scheduler #(
      .SAMPLE_DIV (SD),
      .FIFO_DEPTH (DEPTH),
      .MUTE_WORD  (MUTE)
   ) dut (
      .clk_25mhz   (tb_clk_25mhz),
      .reset       (reset),
      .audio_in    (audio_in),
      .audio_valid (audio_valid),
      .cfg_word    (cfg_word),
      .cfg_req     (cfg_req),
      .cfg_ack     (cfg_ack),
      .dac_data    (dac_data),
      .dac_start   (dac_start),
      .dac_busy    (dac_busy),
      .fifo_level  (fifo_level),
      .underrun    (underrun),
      .overflow    (overflow),
      .late        (late)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // reference model: slot position, pending flag, sample queue, channel
   int          m_cnt;
   bit          m_pend;
   bit          m_go;
   bit          m_seen;
   int          m_since;
   logic [15:0] m_q[$];
   logic [15:0] m_last;
   logic [15:0] m_data;

   // driver model: busy rises drv_d cycles after start for drv_l cycles
   int drv_t = -1;
   int drv_d = 1;
   int drv_l = 10;
   int def_d = 1;
   int def_l = 40;
   int ov_d  = 1;
   int ov_l  = 10;
   int ov_n  = 0;
   bit drv_rand = 1'b0;

   bit          cfg_arm  = 1'b0;
   bit          cfg_drop = 1'b0;
   logic [15:0] cfg_next = '0;

   int          l_cyc[$];
   logic [15:0] l_word[$];
   int          n_under;
   int          n_over;
   int          n_late;
   logic [15:0] dv [5];

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc %0d: got %0h want %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [15:0] sub_word();
      return HOLD ? m_last : MUTE;
   endfunction

   task automatic model_reset();
      m_cnt   = 0;
      m_pend  = 1'b0;
      m_go    = 1'b0;
      m_seen  = 1'b0;
      m_since = -1;
      m_q.delete();
      m_last  = MUTE;
      m_data  = 16'h0000;
   endtask

   task automatic next_frame();
      int r;
      if (ov_n > 0) begin
         drv_d = ov_d;
         drv_l = ov_l;
         ov_n--;
      end else if (drv_rand) begin
         r     = $urandom_range(0, 99);
         drv_d = (r < 5) ? 0 : ((r < 50) ? 1 : 2);
         drv_l = (r % 10 == 0) ? $urandom_range(SD + 5, 2 * SD + 20)
                               : $urandom_range(1, 45);
      end else begin
         drv_d = def_d;
         drv_l = def_l;
      end
   endtask

   task automatic step(input bit r, input bit v, input logic [15:0] d);
      bit          tick;
      bit          free;
      bit          sa;
      bit          sc;
      logic [15:0] w;
      @(negedge tb_clk_25mhz);
      if (drv_t >= 0) drv_t++;
      if (drv_t > drv_d + drv_l + 2) drv_t = -1;
      dac_busy = (drv_t >= 0) && (drv_d > 0) && (drv_t >= drv_d)
                 && (drv_t < drv_d + drv_l);
      reset       = r;
      audio_valid = v;
      audio_in    = d;
      if (cfg_drop) begin
         cfg_req  = 1'b0;
         cfg_drop = 1'b0;
      end else if (cfg_arm && !cfg_req) begin
         cfg_req  = 1'b1;
         cfg_word = cfg_next;
         cfg_arm  = 1'b0;
      end
      #1;
      if (!r) model_reset();
      tick = r && (m_cnt == SD - 1);
      free = r && !m_go && (m_since < 0);
      sa   = free && m_pend;
      sc   = free && !m_pend && !tick && cfg_req;
      chk("dac_start",  dac_start,  m_go);
      chk("cfg_ack",    cfg_ack,    sc);
      chk("underrun",   underrun,   sa && m_q.size() == 0);
      chk("overflow",   overflow,   r && v && m_q.size() == DEPTH && !sa);
      chk("late",       late,       tick && m_pend && !sa);
      chk("fifo_level", fifo_level, m_q.size());
      chk("dac_data",   dac_data,   m_data);
      if (underrun === 1'b1) n_under++;
      if (overflow === 1'b1) n_over++;
      if (late === 1'b1)     n_late++;
      if (cfg_ack === 1'b1)  cfg_drop = 1'b1;
      if (dac_start === 1'b1) begin
         l_cyc.push_back(cyc);
         l_word.push_back(dac_data);
         drv_t = 0;
         next_frame();
      end
      if (!r) begin
         drv_t = -1;
      end else begin
         if (m_go) begin
            m_go    = 1'b0;
            m_since = 0;
            m_seen  = 1'b0;
         end else if (m_since >= 0) begin
            if (m_seen) begin
               if (!dac_busy) m_since = -1;
            end else if (dac_busy) m_seen = 1'b1;
            else if (m_since == 1) m_since = -1;
            else m_since = 1;
         end
         if (sa) begin
            if (m_q.size() == 0) w = sub_word();
            else w = m_q.pop_front();
            m_data = w;
            m_last = w;
            m_go   = 1'b1;
         end
         if (sc) begin
            m_data = cfg_word;
            m_go   = 1'b1;
         end
         if (v && m_q.size() < DEPTH) m_q.push_back(d);
         m_pend = tick || (m_pend && !sa);
         m_cnt  = tick ? 0 : m_cnt + 1;
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b1, 1'b0, 16'h0000);
   endtask

   task automatic wait_cnt(input int k);
      bit ok = 1'b0;
      for (int i = 0; i <= SD; i++) begin
         if (m_cnt == k) begin
            ok = 1'b1;
            break;
         end
         idle(1);
      end
      chk("align_bound", ok, 1'b1);
   endtask

   task automatic clear_log();
      l_cyc.delete();
      l_word.delete();
      n_under = 0;
      n_over  = 0;
      n_late  = 0;
   endtask

   task automatic request_cfg(input logic [15:0] w);
      cfg_next = w;
      cfg_arm  = 1'b1;
   endtask

   initial begin
      int rel;
      int rate;
      bit found;
      model_reset();
      clear_log();

      repeat (4) step(1'b0, 1'b0, 16'h0000);

      // two samples paced one slot apart
      clear_log();
      rel = cyc;
      idle(1);
      step(1'b1, 1'b1, 16'hC0DE);
      step(1'b1, 1'b1, 16'h1234);
      idle(189);
      chk("b_count", l_word.size(), 2);
      if (l_word.size() >= 2) begin
         chk("b_w0",    l_word[0], 16'hC0DE);
         chk("b_w1",    l_word[1], 16'h1234);
         chk("b_first", l_cyc[0] - rel, SD + 1);
         chk("b_gap",   l_cyc[1] - l_cyc[0], SD);
      end

      // underrun after BEEF
      wait_cnt(10);
      clear_log();
      step(1'b1, 1'b1, 16'hBEEF);
      idle(2 * SD);
      chk("c_count", l_word.size(), 2);
      chk("c_under", n_under, 1);
      if (l_word.size() >= 2) begin
         chk("c_w0", l_word[0], 16'hBEEF);
         chk("c_w1", l_word[1], HOLD ? 16'hBEEF : MUTE);
      end

      // overflow on fifth push, first four kept in order
      wait_cnt(5);
      clear_log();
      for (int i = 0; i < 5; i++) dv[i] = 16'($urandom);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, dv[i]);
      chk("d_over", n_over, 1);
      idle(4 * SD);
      chk("d_count", l_word.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < l_word.size()) chk("d_order", l_word[i], dv[i]);

      // config mid-slot, then config raised in the tick cycle
      def_l = 10;
      wait_cnt(50);
      clear_log();
      rel = cyc;
      request_cfg(16'h7001);
      idle(4);
      chk("e_count", l_word.size(), 1);
      if (l_word.size() >= 1) begin
         chk("e_word", l_word[0], 16'h7001);
         chk("e_lat",  l_cyc[0] - rel, 1);
      end
      wait_cnt(SD - 1);
      clear_log();
      request_cfg(16'h7002);
      idle(SD);
      chk("e2_count", l_word.size(), 2);
      if (l_word.size() >= 2) begin
         chk("e2_audio", l_word[0], HOLD ? dv[3] : MUTE);
         chk("e2_cfg",   l_word[1], 16'h7002);
      end

      // frame outlasting two slot ticks
      wait_cnt(SD - 1);
      clear_log();
      ov_d = 1;
      ov_l = 2 * SD + 8;
      ov_n = 1;
      idle(3 * SD);
      chk("f_late",  n_late, 1);
      chk("f_count", l_word.size(), 2);

      // driver never raises busy
      wait_cnt(SD - 1);
      clear_log();
      ov_d = 0;
      ov_l = 0;
      ov_n = 2;
      idle(2 * SD);
      chk("g_count", l_word.size(), 2);

      // reset while a frame is in flight
      wait_cnt(SD - 1);
      ov_d  = 1;
      ov_l  = 40;
      ov_n  = 1;
      found = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (m_seen && m_since >= 0) begin
            found = 1'b1;
            break;
         end
         idle(1);
      end
      chk("h_inframe", found, 1'b1);
      step(1'b0, 1'b1, 16'hAAAA);
      step(1'b0, 1'b0, 16'h0000);
      clear_log();
      rel = cyc;
      idle(SD + 4);
      chk("h_count", l_word.size(), 1);
      if (l_word.size() >= 1) chk("h_first", l_cyc[0] - rel, SD + 1);

      // random traffic
      drv_rand = 1'b1;
      rate     = 8;
      for (int i = 0; i < 6000; i++) begin
         if (i % 500 == 0) rate = (($urandom & 1) != 0) ? 3 : 60;
         if (!cfg_arm && !cfg_req && $urandom_range(0, 199) == 0)
            request_cfg(16'($urandom));
         step($urandom_range(0, 2499) != 0,
              $urandom_range(0, rate - 1) == 0,
              16'($urandom));
      end
      idle(3 * SD);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
